// File: rtl/mac_pkg.sv
// Constants, header layout and state encoding shared by the MAC receive path.
package mac_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'hbc;
    localparam logic [31:0] CRC_POLY      = 32'h04c11db7;
    localparam logic [31:0] CRC_PRESET    = 32'hffff_ffff;

    localparam int DST_OFF  = 0;
    localparam int SRC_OFF  = 6;
    localparam int TYPE_OFF = 12;
    localparam int HDR_LEN  = 14;
    localparam int CRC_LEN  = 4;

    localparam logic [47:0] BCAST_MAC = 48'hffff_ffff_ffff;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_HEADER,
        ST_DATA,
        ST_CHECK,
        ST_DROP
    } rx_state_t;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Bytes go out LSB first, so the register shifts right against the reflected polynomial.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ reflect32(CRC_POLY)) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/mac_crc_rx.sv
// Byte-wide Ethernet CRC-32 for the receive path; output is the complemented register,
// which is the value the transmitter appends to the frame.
module mac_crc_rx
    import mac_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;

    // NOTE: state is updated with <= so every reader in this edge sees the pre-edge value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_crc <= CRC_PRESET;
        end else if (i_init) begin
            r_crc <= CRC_PRESET;
        end else if (i_en) begin
            r_crc <= crc32_byte(r_crc, i_data);
        end
    end

    assign o_crc = ~r_crc;

endmodule

// File: rtl/mac_rx.sv
// Receive MAC framer: strips preamble, parses and filters the header, forwards payload
// through a 4-byte delay line so the trailing CRC never leaves the block, then reports status.
module mac_rx #(
    parameter logic [47:0] LOCAL_MAC     = 48'hdeadbeefcafe,
    parameter logic [7:0]  PREAMBLE_BYTE = mac_pkg::PREAMBLE_BYTE,
    parameter int          PREAMBLE_LEN  = 8,
    parameter int          MAX_PAYLOAD   = 1500,
    parameter bit          PROMISC       = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  mac_in,
    input  logic        mac_in_valid,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic [47:0] rx_dst_mac,
    output logic [47:0] rx_src_mac,
    output logic [15:0] rx_type,
    output logic        rx_done,
    output logic        rx_crc_ok,
    output logic        rx_err_runt,
    output logic        rx_err_long,
    output logic        rx_dropped
);

    import mac_pkg::*;

    localparam logic [3:0]  PRE_LAST  = 4'(PREAMBLE_LEN - 1);
    localparam logic [3:0]  DST_LAST  = 4'(SRC_OFF - 1);
    localparam logic [3:0]  HDR_LAST  = 4'(HDR_LEN - 1);
    localparam logic [15:0] MIN_FRAME = 16'(HDR_LEN + CRC_LEN);
    localparam logic [15:0] PAY_MAX   = 16'(MAX_PAYLOAD);

    rx_state_t   r_state;
    rx_state_t   w_state_nxt;

    logic [7:0]  r_dl [4];
    logic [2:0]  r_dl_cnt;
    logic [3:0]  r_pre_cnt;
    logic [3:0]  r_hdr_cnt;
    logic [15:0] r_byte_cnt;
    logic [15:0] r_pay_cnt;
    logic        r_long;

    logic        w_shift;
    logic        w_emerge;
    logic [7:0]  w_byte;
    logic [47:0] w_dst_full;
    logic        w_addr_ok;
    logic [31:0] w_rx_fcs;
    logic [31:0] w_crc;
    logic        w_crc_init;
    logic        w_runt;
    logic        w_fcs_ok;

    // Every post-preamble byte enters the delay line; once it is full, each new byte pushes
    // out the oldest one, so the last four bytes of a frame (its CRC) are never emitted.
    assign w_shift    = mac_in_valid && (r_state == ST_HEADER || r_state == ST_DATA);
    assign w_emerge   = w_shift && (r_dl_cnt == 3'd4);
    assign w_byte     = r_dl[3];
    assign w_dst_full = {rx_dst_mac[39:0], w_byte};
    assign w_addr_ok  = PROMISC || (w_dst_full == LOCAL_MAC) || (w_dst_full == BCAST_MAC);
    assign w_rx_fcs   = {r_dl[0], r_dl[1], r_dl[2], r_dl[3]};
    assign w_runt     = (r_byte_cnt < MIN_FRAME);
    assign w_fcs_ok   = (r_dl_cnt == 3'd4) && (w_rx_fcs == w_crc);
    assign w_crc_init = (r_state == ST_IDLE) || (r_state == ST_CHECK);

    mac_crc_rx u_crc (
        .clk    (clk),
        .rst    (rst),
        .i_init (w_crc_init),
        .i_en   (w_emerge),
        .i_data (w_byte),
        .o_crc  (w_crc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: w_state_nxt is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (mac_in_valid) begin
                    w_state_nxt = (mac_in == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!mac_in_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (mac_in != PREAMBLE_BYTE) begin
                    w_state_nxt = ST_DROP;
                end else if (r_pre_cnt == PRE_LAST) begin
                    w_state_nxt = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (!mac_in_valid) begin
                    w_state_nxt = ST_CHECK;
                end else if (w_emerge && r_hdr_cnt == DST_LAST && !w_addr_ok) begin
                    w_state_nxt = ST_DROP;
                end else if (w_emerge && r_hdr_cnt == HDR_LAST) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!mac_in_valid) w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                w_state_nxt = mac_in_valid ? ST_DROP : ST_IDLE;
            end
            ST_DROP: begin
                if (!mac_in_valid) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: the delay line is four ordinary flops, so it is cleared by reset like the rest.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) r_dl[i] <= '0;
            r_dl_cnt    <= '0;
            r_pre_cnt   <= '0;
            r_hdr_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_pay_cnt   <= '0;
            r_long      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_sof      <= 1'b0;
            rx_dst_mac  <= '0;
            rx_src_mac  <= '0;
            rx_type     <= '0;
            rx_done     <= 1'b0;
            rx_crc_ok   <= 1'b0;
            rx_err_runt <= 1'b0;
            rx_err_long <= 1'b0;
            rx_dropped  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_sof   <= 1'b0;
            rx_done  <= 1'b0;

            if (w_shift) begin
                r_dl[0] <= mac_in;
                r_dl[1] <= r_dl[0];
                r_dl[2] <= r_dl[1];
                r_dl[3] <= r_dl[2];
                if (r_dl_cnt != 3'd4) r_dl_cnt <= r_dl_cnt + 3'd1;
                if (r_byte_cnt != '1) r_byte_cnt <= r_byte_cnt + 16'd1;
            end

            if (w_emerge && r_state == ST_HEADER) begin
                r_hdr_cnt <= r_hdr_cnt + 4'd1;
                if (r_hdr_cnt < 4'(SRC_OFF)) begin
                    rx_dst_mac <= w_dst_full;
                end else if (r_hdr_cnt < 4'(TYPE_OFF)) begin
                    rx_src_mac <= {rx_src_mac[39:0], w_byte};
                end else begin
                    rx_type <= {rx_type[7:0], w_byte};
                end
            end

            // Bytes beyond the payload limit are swallowed and only flagged.
            if (w_emerge && r_state == ST_DATA) begin
                if (r_pay_cnt < PAY_MAX) begin
                    rx_data   <= w_byte;
                    rx_valid  <= 1'b1;
                    rx_sof    <= (r_pay_cnt == '0);
                    r_pay_cnt <= r_pay_cnt + 16'd1;
                end else begin
                    r_long <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    r_dl_cnt   <= '0;
                    r_hdr_cnt  <= '0;
                    r_byte_cnt <= '0;
                    r_pay_cnt  <= '0;
                    r_long     <= 1'b0;
                    r_pre_cnt  <= mac_in_valid ? 4'd1 : 4'd0;
                end
                ST_PREAMBLE: begin
                    if (mac_in_valid) r_pre_cnt <= r_pre_cnt + 4'd1;
                end
                ST_CHECK: begin
                    rx_done     <= 1'b1;
                    rx_crc_ok   <= !w_runt && w_fcs_ok;
                    rx_err_runt <= w_runt;
                    rx_err_long <= r_long;
                    rx_dropped  <= 1'b0;
                end
                ST_DROP: begin
                    if (!mac_in_valid) begin
                        rx_done     <= 1'b1;
                        rx_crc_ok   <= 1'b0;
                        rx_err_runt <= 1'b0;
                        rx_err_long <= 1'b0;
                        rx_dropped  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_rx.sv
// Directed bench for mac_rx: builds Ethernet frames with their own CRC-32, scoreboards
// payload bytes (value, sof, arrival cycle) and per-frame status.
module tb_mac_rx;

    localparam logic [47:0] LOCAL = 48'hdeadbeefcafe;
    localparam logic [47:0] SRC   = 48'h0200_0000_0001;
    localparam logic [47:0] BCAST = 48'hffff_ffff_ffff;
    localparam int          MAXP  = 1500;
    localparam int          PAY0  = 8 + 14;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  mac_in = 8'd0;
    logic        mac_in_valid = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_done;
    logic [47:0] rx_dst_mac, rx_src_mac;
    logic [15:0] rx_type;
    logic        rx_crc_ok, rx_err_runt, rx_err_long, rx_dropped;

    mac_rx #(
        .LOCAL_MAC     (LOCAL),
        .PREAMBLE_BYTE (8'hbc),
        .PREAMBLE_LEN  (8),
        .MAX_PAYLOAD   (MAXP),
        .PROMISC       (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mac_in       (mac_in),
        .mac_in_valid (mac_in_valid),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_sof       (rx_sof),
        .rx_dst_mac   (rx_dst_mac),
        .rx_src_mac   (rx_src_mac),
        .rx_type      (rx_type),
        .rx_done      (rx_done),
        .rx_crc_ok    (rx_crc_ok),
        .rx_err_runt  (rx_err_runt),
        .rx_err_long  (rx_err_long),
        .rx_dropped   (rx_dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       sof;
        int         cyc;
    } exp_byte_t;

    exp_byte_t  sb[$];
    logic [3:0] st_q[$];     // {crc_ok, runt, long, dropped}
    logic [7:0] frame_q[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int rx_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r = c;
        for (int k = 0; k < 8; k++) begin
            if (r[0] ^ d[k]) r = (r >> 1) ^ 32'hedb88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic build_frame(input logic [47:0] dst, input int plen, input int flip_idx);
        logic [31:0] crc;
        frame_q.delete();
        for (int i = 0; i < 8; i++) frame_q.push_back(8'hbc);
        for (int i = 5; i >= 0; i--) frame_q.push_back(dst[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) frame_q.push_back(SRC[i*8 +: 8]);
        frame_q.push_back(8'h08);
        frame_q.push_back(8'h00);
        for (int i = 0; i < plen; i++) frame_q.push_back(8'(i));
        crc = 32'hffff_ffff;
        for (int i = 8; i < frame_q.size(); i++) crc = crc_step(crc, frame_q[i]);
        crc = ~crc;
        for (int i = 0; i < 4; i++) frame_q.push_back(crc[i*8 +: 8]);
        if (flip_idx >= 0) frame_q[PAY0 + flip_idx] ^= 8'h01;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, 64'({rx_data, rx_valid, rx_sof, rx_done, rx_crc_ok,
                                   rx_err_runt, rx_err_long, rx_dropped}), 64'd0);
        check({tag, "_dst"}, 64'(rx_dst_mac), 64'd0);
        check({tag, "_src_type"}, {rx_src_mac, rx_type}, 64'd0);
    endtask

    // Drives frame_q[0..nbytes-1] back to back; rst_at >= 0 pulses reset at that byte instead.
    task automatic drive(input int nbytes, input bit fwd, input int rst_at);
        for (int i = 0; i < nbytes; i++) begin
            @(posedge clk);
            #1;
            if (i == rst_at) begin
                rst = 1'b0;
                mac_in_valid = 1'b0;
                mac_in = 8'd0;
                sb.delete();
                #1 check_outputs_zero("midframe_rst");
                repeat (3) @(posedge clk);
                #1 rst = 1'b1;
                return;
            end
            mac_in = frame_q[i];
            mac_in_valid = 1'b1;
            if (fwd && i >= PAY0 && i < int'(frame_q.size()) - 4 && (i - PAY0) < MAXP)
                sb.push_back(exp_byte_t'{frame_q[i], 1'(i == PAY0), cyc + 5});
        end
        @(posedge clk);
        #1;
        mac_in_valid = 1'b0;
        mac_in = 8'd0;
    endtask

    task automatic wait_done(input string tag);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < 30) begin
            @(posedge clk);
            n++;
        end
        check(tag, 64'(done_cnt - start), 64'd1);
        repeat (4) @(posedge clk);
    endtask

    task automatic expect_no_done(input string tag);
        int start = done_cnt;
        repeat (12) @(posedge clk);
        check(tag, 64'(done_cnt - start), 64'd0);
    endtask

    always @(negedge clk) begin
        exp_byte_t e;
        if (rst && rx_valid) begin
            rx_cnt++;
            if (sb.size() == 0) begin
                check("rx_unexpected_byte", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                check("rx_data", 64'(rx_data), 64'(e.data));
                check("rx_sof", 64'(rx_sof), 64'(e.sof));
                check("rx_latency_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (rst && rx_done) begin
            done_cnt++;
            if (st_q.size() == 0) begin
                check("rx_done_unexpected", 64'(st_q.size()), 64'd1);
            end else begin
                check("rx_status", 64'({rx_crc_ok, rx_err_runt, rx_err_long, rx_dropped}),
                      64'(st_q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst = 1'b0;
        #2 check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        // Good unicast frame, 46-byte payload.
        build_frame(LOCAL, 46, -1);
        st_q.push_back(4'b1000);
        c0 = rx_cnt;
        drive(frame_q.size(), 1'b1, -1);
        wait_done("good_done");
        check("good_drained", 64'(sb.size()), 64'd0);
        check("good_rx_count", 64'(rx_cnt - c0), 64'd46);
        check("good_dst", 64'(rx_dst_mac), 64'(LOCAL));
        check("good_src", 64'(rx_src_mac), 64'(SRC));
        check("good_type", 64'(rx_type), 64'h0800);

        // Payload byte 10 corrupted after the CRC was computed.
        build_frame(LOCAL, 46, 10);
        st_q.push_back(4'b0000);
        drive(frame_q.size(), 1'b1, -1);
        wait_done("corrupt_done");
        check("corrupt_drained", 64'(sb.size()), 64'd0);

        // Foreign destination is filtered.
        build_frame(48'h1122_3344_5566, 46, -1);
        st_q.push_back(4'b0001);
        c0 = rx_cnt;
        drive(frame_q.size(), 1'b0, -1);
        wait_done("filtered_done");
        check("filtered_rx_count", 64'(rx_cnt - c0), 64'd0);

        // Broadcast destination is accepted.
        build_frame(BCAST, 46, -1);
        st_q.push_back(4'b1000);
        drive(frame_q.size(), 1'b1, -1);
        wait_done("bcast_done");
        check("bcast_drained", 64'(sb.size()), 64'd0);
        check("bcast_dst", 64'(rx_dst_mac), 64'(BCAST));

        // Bad preamble byte 4.
        build_frame(LOCAL, 46, -1);
        frame_q[3] = 8'h55;
        st_q.push_back(4'b0001);
        drive(frame_q.size(), 1'b0, -1);
        wait_done("bad_pre_done");

        // Valid falls after three preamble bytes: silent.
        build_frame(LOCAL, 46, -1);
        drive(3, 1'b0, -1);
        expect_no_done("pre_abort_no_done");

        // Runt: 10 post-preamble bytes.
        build_frame(LOCAL, 46, -1);
        st_q.push_back(4'b0100);
        drive(8 + 10, 1'b0, -1);
        wait_done("runt_done");

        // Over-long payload: 1501 bytes, only 1500 forwarded.
        build_frame(LOCAL, 1501, -1);
        st_q.push_back(4'b1010);
        c0 = rx_cnt;
        drive(frame_q.size(), 1'b1, -1);
        wait_done("long_done");
        check("long_drained", 64'(sb.size()), 64'd0);
        check("long_rx_count", 64'(rx_cnt - c0), 64'd1500);

        // Reset in the middle of the payload.
        build_frame(LOCAL, 46, -1);
        drive(frame_q.size(), 1'b1, PAY0 + 20);
        expect_no_done("rst_no_done");

        // Clean frame after reset.
        build_frame(LOCAL, 46, -1);
        st_q.push_back(4'b1000);
        c0 = rx_cnt;
        drive(frame_q.size(), 1'b1, -1);
        wait_done("post_rst_done");
        check("post_rst_drained", 64'(sb.size()), 64'd0);
        check("post_rst_rx_count", 64'(rx_cnt - c0), 64'd46);
        check("status_queue_empty", 64'(st_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
